// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants and types for the instruction store and its load/run controller.
package imem_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  localparam logic [3:0]    HALT_OP  = 4'hF;
  localparam logic [DW-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader handshake, run control and CPU fetch bus of the instruction store.
interface imem_load_ctrl_if;
  import imem_pkg::*;

  logic          load_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          run_start;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          cpu_run;
  logic          halted;
  logic [AW:0]   load_count;

  // Controller side.
  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, run_start, fetch_req, fetch_addr,
    output ld_ready, fetch_instr, fetch_valid, cpu_run, halted, load_count
  );

  // Loader / CPU side.
  modport master (
    output load_start, ld_valid, ld_data, ld_last, run_start, fetch_req, fetch_addr,
    input  ld_ready, fetch_instr, fetch_valid, cpu_run, halted, load_count
  );

endinterface

// File: rtl/imem_load_ctrl_ram16.sv
// DEPTH x DW register-array store: async clear to NOPs, one sync write port,
// one registered read port. rnext_o is the word the read port would capture,
// so the controller can decode HALT on the same edge as the read.
module imem_ram16
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic [DW-1:0] rnext_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // Next-state of the array and read register.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_WORD;
      rdata_q <= NOP_WORD;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign rnext_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_load_ctrl.sv
// Load/run controller around the writable instruction store.
module imem_load_ctrl
  import imem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  imem_load_ctrl_if.slave  bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fv_q, fv_d;
  logic          we, re;
  logic [DW-1:0] rdata, rnext;

  imem_ram16 u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (bus.ld_data),
    .re_i    (re),
    .raddr_i (bus.fetch_addr),
    .rdata_o (rdata),
    .rnext_o (rnext)
  );

  // Next-state, write/read strobes. load_start > run_start > fetch_req everywhere.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    re      = 1'b0;
    if (bus.load_start) begin
      state_d = LOAD;
      wptr_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.run_start) state_d = RUN;
        LOAD: begin
          if (bus.ld_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (cnt_q != (AW+1)'(DEPTH)) cnt_d = cnt_q + (AW+1)'(1);
            if (bus.ld_last || wptr_q == AW'(DEPTH - 1)) state_d = IDLE;
          end
        end
        RUN: begin
          if (!bus.run_start && bus.fetch_req) begin
            re = 1'b1;
            if (rnext[DW-1:DW-4] == HALT_OP) state_d = HALT;
          end
        end
        HALT: if (bus.run_start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    fv_d = re;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.ld_ready    = (state_q == LOAD);
  assign bus.cpu_run     = (state_q == RUN);
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_instr = rdata;
  assign bus.fetch_valid = fv_q;
  assign bus.load_count  = cnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the store and its mode.
module tb_imem_load_ctrl;

  logic clk;
  logic rst_n;
  imem_load_ctrl_if bus ();

  imem_load_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int MIdle = 0, MLoad = 1, MRun = 2, MHalt = 3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem_m [16];
  int          mode_m;
  int          wp_m;
  int          cnt_m;
  logic [15:0] fi_m;
  logic        fv_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    mode_m = MIdle;
    wp_m   = 0;
    cnt_m  = 0;
    fi_m   = 16'h0000;
    fv_m   = 1'b0;
  endtask

  task automatic check_all();
    check_eq("ld_ready",    bus.ld_ready,    mode_m == MLoad);
    check_eq("cpu_run",     bus.cpu_run,     mode_m == MRun);
    check_eq("halted",      bus.halted,      mode_m == MHalt);
    check_eq("load_count",  bus.load_count,  cnt_m);
    check_eq("fetch_valid", bus.fetch_valid, fv_m);
    check_eq("fetch_instr", bus.fetch_instr, fi_m);
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, compare.
  task automatic step(input logic ls, input logic rs, input logic lv, input logic last,
                      input logic [15:0] d, input logic fr, input logic [3:0] fa);
    bus.load_start = ls;
    bus.run_start  = rs;
    bus.ld_valid   = lv;
    bus.ld_last    = last;
    bus.ld_data    = d;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    @(posedge clk);
    #1;
    fv_m = 1'b0;
    if (ls) begin
      mode_m = MLoad;
      wp_m   = 0;
      cnt_m  = 0;
    end else if (mode_m == MLoad) begin
      if (lv) begin
        mem_m[wp_m] = d;
        if (cnt_m < 16) cnt_m++;
        if (last || wp_m == 15) mode_m = MIdle;
        wp_m = (wp_m + 1) % 16;
      end
    end else if (rs) begin
      if (mode_m != MLoad) mode_m = MRun;
    end else if (mode_m == MRun && fr) begin
      fi_m = mem_m[fa];
      fv_m = 1'b1;
      if (fi_m[15:12] == 4'hF) mode_m = MHalt;
    end
    check_all();
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    step(1'b0, 1'b0, 1'b1, last, d, 1'b0, 4'h0);
  endtask

  task automatic fetch(input logic [3:0] a);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, a);
  endtask

  logic [15:0] prog [7] = '{16'h0000, 16'h10F5, 16'h5000, 16'h8000, 16'h900A, 16'hB002,
                            16'hF000};

  initial begin
    bus.load_start = 1'b0;
    bus.run_start  = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    bus.ld_data    = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fetches ignored in IDLE, then all NOPs in RUN.
    for (int i = 0; i < 16; i++) fetch(4'(i));
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) fetch(4'(i));
    idle_cycle();

    // Countup program with ld_last on the 7th word.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) load_word(prog[i], i == 6);
    check_eq("cnt_countup", bus.load_count, 7);
    check_eq("idle_after_load", bus.ld_ready, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) fetch(4'(i));
    check_eq("halt_valid", bus.fetch_valid, 1'b1);
    check_eq("halt_flag", bus.halted, 1'b1);
    check_eq("halt_cpu_run", bus.cpu_run, 1'b0);
    check_eq("halt_word", bus.fetch_instr, 16'hF000);
    fetch(4'h0);

    // Full 16-word load, auto exit, 17th word refused.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) load_word(16'($urandom) & 16'hEFFF, 1'b0);
    check_eq("cnt_full", bus.load_count, 16);
    check_eq("ready17", bus.ld_ready, 1'b0);
    load_word(16'h1234, 1'b0);
    check_eq("cnt_after17", bus.load_count, 16);

    // load_start with a fetch pending in RUN: fetch dropped, partial overwrite.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    fetch(4'h3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'h5);
    check_eq("abort_valid", bus.fetch_valid, 1'b0);
    check_eq("abort_run", bus.cpu_run, 1'b0);
    check_eq("abort_load", bus.ld_ready, 1'b1);
    load_word(16'hA111, 1'b0);
    load_word(16'hF222, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    for (int i = 15; i >= 2; i--) fetch(4'(i));
    fetch(4'h0);
    fetch(4'h1);

    // HALT with load_start and run_start together: LOAD wins.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check_eq("halt_ls_ready", bus.ld_ready, 1'b1);
    check_eq("halt_ls_halted", bus.halted, 1'b0);

    // Reset after three words of a load.
    for (int i = 0; i < 3; i++) load_word(16'h7000 + 16'(i), 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    fetch(4'h1);
    check_eq("post_rst_word", bus.fetch_instr, 16'h0000);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, 1'($urandom),
           $urandom_range(0, 7) == 0, 16'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
